// File: rtl/writeback_stage.sv
// rtl/writeback_stage.sv - MEM/WB pipeline register and register-file write-back driver
//
// Purpose:
//   Captures the instruction retiring from the MEM stage, extends load data,
//   holds the stage while a slow data-memory return is outstanding, and drives
//   the register-file write port. Every write-port output is registered so it
//   only moves at posedge; the register file samples it at the following negedge.
//
// Ports:
//   clock, reset_n          clock and asynchronous active-low reset
//   in_valid .. in_link_addr instruction presented by the MEM stage
//   flush                   drop the incoming instruction / kill a pending load
//   mem_read_data/_valid    data-memory return word and its qualifier
//   wb_stall                high while a load is waiting on memory
//   control_reg_write/_write_id/reg_write_value  register-file write port
//   retired_count           committed-instruction counter (wraps)

module writeback_stage #(
  parameter int         COUNT_WIDTH = 32,
  parameter logic [4:0] LINK_REG    = 5'd31
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   in_valid,
  input  logic                   in_reg_write,
  input  logic [4:0]             in_write_id,
  input  logic [31:0]            in_alu_result,
  input  logic                   in_mem_to_reg,
  input  logic [1:0]             in_load_size,
  input  logic                   in_load_unsigned,
  input  logic [1:0]             in_byte_offset,
  input  logic                   in_link,
  input  logic [31:0]            in_link_addr,
  input  logic                   flush,
  input  logic [31:0]            mem_read_data,
  input  logic                   mem_data_valid,
  output logic                   wb_stall,
  output logic                   control_reg_write,
  output logic [4:0]             control_write_id,
  output logic [31:0]            reg_write_value,
  output logic [COUNT_WIDTH-1:0] retired_count
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_COMMIT = 2'd1,
    S_WAIT   = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next_state;

  // Entry fields kept while a load waits on memory.
  logic       r_p_reg_write;
  logic [4:0] r_p_write_id;
  logic [1:0] r_p_load_size;
  logic       r_p_unsigned;
  logic [1:0] r_p_offset;

  logic                   r_wr;
  logic [4:0]             r_id;
  logic [31:0]            r_value;
  logic [COUNT_WIDTH-1:0] r_count;

  logic        w_wr;
  logic [4:0]  w_id;
  logic [31:0] w_value;
  logic        w_latch;

  // Sub-word select and extension; size 2'b11 is treated as a full word.
  function automatic logic [31:0] f_ext(input logic [31:0] word, input logic [1:0] size,
                                        input logic uns, input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(word >> {off, 3'b000});
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      2'b01:   f_ext = uns ? {16'h0000, h} : {{16{h[15]}}, h};
      2'b10:   f_ext = uns ? {24'h000000, b} : {{24{b[7]}}, b};
      default: f_ext = word;
    endcase
  endfunction

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = S_IDLE;
    w_wr         = 1'b0;
    w_id         = r_id;
    w_value      = r_value;
    w_latch      = 1'b0;
    case (r_state)
      S_WAIT: begin
        if (flush) begin
          w_next_state = S_IDLE;
        end else if (mem_data_valid) begin
          w_next_state = S_COMMIT;
          w_wr         = r_p_reg_write && (r_p_write_id != 5'd0);
          w_id         = r_p_write_id;
          w_value      = f_ext(mem_read_data, r_p_load_size, r_p_unsigned, r_p_offset);
        end else begin
          w_next_state = S_WAIT;
        end
      end
      default: begin
        // IDLE and COMMIT both capture; this gives back-to-back commits at 1 IPC.
        if (in_valid && !flush) begin
          if (in_link) begin
            w_next_state = S_COMMIT;
            w_wr         = (LINK_REG != 5'd0);
            w_id         = LINK_REG;
            w_value      = in_link_addr;
          end else if (in_mem_to_reg && !mem_data_valid) begin
            w_next_state = S_WAIT;
            w_latch      = 1'b1;
          end else begin
            w_next_state = S_COMMIT;
            w_wr         = in_reg_write && (in_write_id != 5'd0);
            w_id         = in_write_id;
            w_value      = in_mem_to_reg
                         ? f_ext(mem_read_data, in_load_size, in_load_unsigned, in_byte_offset)
                         : in_alu_result;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_p_reg_write <= 1'b0;
      r_p_write_id  <= 5'd0;
      r_p_load_size <= 2'd0;
      r_p_unsigned  <= 1'b0;
      r_p_offset    <= 2'd0;
      r_wr          <= 1'b0;
      r_id          <= 5'd0;
      r_value       <= 32'd0;
      r_count       <= '0;
    end else begin
      if (w_latch) begin
        r_p_reg_write <= in_reg_write;
        r_p_write_id  <= in_write_id;
        r_p_load_size <= in_load_size;
        r_p_unsigned  <= in_load_unsigned;
        r_p_offset    <= in_byte_offset;
      end
      r_wr    <= w_wr;
      r_id    <= w_id;
      r_value <= w_value;
      // Counted on the edge that leaves COMMIT, writing or not.
      if (r_state == S_COMMIT) r_count <= r_count + 1'b1;
    end
  end

  assign wb_stall          = (r_state == S_WAIT);
  assign control_reg_write = r_wr;
  assign control_write_id  = r_id;
  assign reg_write_value   = r_value;
  assign retired_count     = r_count;

endmodule

// File: tb/tb_writeback_stage.sv
// tb/tb_writeback_stage.sv - scoreboard bench for writeback_stage

module tb_writeback_stage;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid, in_reg_write, in_mem_to_reg, in_load_unsigned, in_link;
  logic [4:0]  in_write_id;
  logic [31:0] in_alu_result, in_link_addr, mem_read_data;
  logic [1:0]  in_load_size, in_byte_offset;
  logic        flush, mem_data_valid;
  logic        wb_stall, control_reg_write;
  logic [4:0]  control_write_id;
  logic [31:0] reg_write_value, retired_count;

  writeback_stage #(.COUNT_WIDTH(32), .LINK_REG(5'd31)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_reg_write(in_reg_write),
    .in_write_id(in_write_id), .in_alu_result(in_alu_result), .in_mem_to_reg(in_mem_to_reg),
    .in_load_size(in_load_size), .in_load_unsigned(in_load_unsigned),
    .in_byte_offset(in_byte_offset), .in_link(in_link), .in_link_addr(in_link_addr),
    .flush(flush), .mem_read_data(mem_read_data), .mem_data_valid(mem_data_valid),
    .wb_stall(wb_stall), .control_reg_write(control_reg_write),
    .control_write_id(control_write_id), .reg_write_value(reg_write_value),
    .retired_count(retired_count)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: an outstanding-load record plus an ordered list of writes.
  logic [36:0] exp_q[$];
  int unsigned m_count = 0;
  bit          m_pending = 0;
  logic        p_wr, p_uns;
  logic [4:0]  p_id;
  logic [1:0]  p_size, p_off;
  bit          exp_stall = 0;
  bit          mon_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_ext(input logic [31:0] word, input logic [1:0] size,
                                        input logic uns, input logic [1:0] off);
    int unsigned v;
    if (size == 2'd1) begin
      v = (word >> ((off >= 2) ? 16 : 0)) & 32'hFFFF;
      if (!uns && v >= 32'h8000) v = v + 32'hFFFF_0000;
    end else if (size == 2'd2) begin
      v = (word >> (off * 8)) & 32'hFF;
      if (!uns && v >= 32'h80) v = v + 32'hFFFF_FF00;
    end else begin
      v = word;
    end
    return v;
  endfunction

  task automatic m_commit(input logic w, input logic [4:0] id, input logic [31:0] v);
    m_count++;
    if (w && id != 0) exp_q.push_back({id, v});
  endtask

  task automatic m_apply();
    if (m_pending) begin
      if (flush) m_pending = 0;
      else if (mem_data_valid) begin
        m_commit(p_wr, p_id, m_ext(mem_read_data, p_size, p_uns, p_off));
        m_pending = 0;
      end
    end else if (in_valid && !flush) begin
      if (in_link) m_commit(1'b1, 5'd31, in_link_addr);
      else if (in_mem_to_reg) begin
        if (mem_data_valid)
          m_commit(in_reg_write, in_write_id,
                   m_ext(mem_read_data, in_load_size, in_load_unsigned, in_byte_offset));
        else begin
          p_wr = in_reg_write; p_id = in_write_id; p_size = in_load_size;
          p_uns = in_load_unsigned; p_off = in_byte_offset; m_pending = 1;
        end
      end else m_commit(in_reg_write, in_write_id, in_alu_result);
    end
  endtask

  task automatic set_in(input logic v, input logic rw, input logic [4:0] id,
                        input logic [31:0] alu, input logic m2r, input logic [1:0] sz,
                        input logic uns, input logic [1:0] off, input logic lnk,
                        input logic [31:0] la, input logic fl, input logic [31:0] md,
                        input logic mv);
    in_valid = v; in_reg_write = rw; in_write_id = id; in_alu_result = alu;
    in_mem_to_reg = m2r; in_load_size = sz; in_load_unsigned = uns; in_byte_offset = off;
    in_link = lnk; in_link_addr = la; flush = fl; mem_read_data = md; mem_data_valid = mv;
  endtask

  task automatic step();
    m_apply();
    @(posedge clock);
    #1;
    exp_stall = m_pending;
  endtask

  task automatic idle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
  endtask

  task automatic expect_now(input string name, input logic w, input logic [4:0] id,
                            input logic [31:0] v);
    @(negedge clock);
    chk({name, "_write"}, {31'd0, control_reg_write}, {31'd0, w});
    if (w) begin
      chk({name, "_id"}, {27'd0, control_write_id}, {27'd0, id});
      chk({name, "_value"}, reg_write_value, v);
    end
  endtask

  // Monitor: stall per cycle, and every asserted write pops the next expected write.
  initial begin
    logic [36:0] e;
    forever begin
      @(negedge clock);
      if (mon_en) begin
        chk("wb_stall", {31'd0, wb_stall}, {31'd0, exp_stall});
        if (control_reg_write) begin
          if (exp_q.size() == 0) chk("unexpected_write", 32'd1, 32'd0);
          else begin
            e = exp_q.pop_front();
            chk("sb_id", {27'd0, control_write_id}, {27'd0, e[36:32]});
            chk("sb_value", reg_write_value, e[31:0]);
          end
        end
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clock);
    #1;
    chk("rst_write", {31'd0, control_reg_write}, 32'd0);
    chk("rst_value", reg_write_value, 32'd0);
    chk("rst_count", retired_count, 32'd0);
    chk("rst_stall", {31'd0, wb_stall}, 32'd0);
    @(negedge clock) reset_n = 1'b1;
    @(posedge clock); #1;
    mon_en = 1;

    // ALU op
    set_in(1, 1, 5, 32'h0000_1234, 0, 0, 0, 0, 0, 0, 0, 0, 0); step();
    idle();
    chk("alu_count", retired_count, 32'd1);

    // loads with data ready
    set_in(1, 1, 7, 32'h3, 1, 2'd2, 0, 2'd3, 0, 0, 0, 32'h80FF_FF7F, 1); step();
    expect_now("lb", 1, 7, 32'hFFFF_FF80);
    set_in(1, 1, 8, 32'h3, 1, 2'd2, 1, 2'd3, 0, 0, 0, 32'h80FF_FF7F, 1); step();
    expect_now("lbu", 1, 8, 32'h0000_0080);
    set_in(1, 1, 9, 32'h2, 1, 2'd1, 0, 2'd2, 0, 0, 0, 32'h80FF_FF7F, 1); step();
    expect_now("lh", 1, 9, 32'hFFFF_80FF);

    // load waiting three cycles; inputs other than flush/mem ignored meanwhile
    set_in(1, 1, 10, 0, 1, 2'd0, 0, 0, 0, 0, 0, 32'hDEAD_BEEF, 0); step();
    set_in(1, 1, 11, 32'h55, 0, 0, 0, 0, 0, 0, 0, 0, 0); step();
    set_in(1, 1, 12, 32'h66, 0, 0, 0, 0, 1, 32'h77, 0, 0, 0); step();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hCAFE_F00D, 1); step();
    expect_now("wait_load", 1, 10, 32'hCAFE_F00D);
    idle();
    chk("wait_count", retired_count, 32'd5);

    // flush during WAIT kills the load
    set_in(1, 1, 13, 0, 1, 2'd0, 0, 0, 0, 0, 0, 0, 0); step();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h1111_1111, 1); step();
    expect_now("flush_wait", 0, 0, 0);
    idle();
    chk("flush_count", retired_count, 32'd5);

    // jal to id 0 and a write to id 0
    set_in(1, 0, 0, 32'h9, 0, 0, 0, 0, 1, 32'h0040_0008, 0, 0, 0); step();
    expect_now("jal", 1, 31, 32'h0040_0008);
    set_in(1, 1, 0, 32'hABCD, 0, 0, 0, 0, 0, 0, 0, 0, 0); step();
    expect_now("id0", 0, 0, 0);
    idle();
    chk("id0_count", retired_count, 32'd7);

    // reset asynchronously while a load waits
    set_in(1, 1, 14, 0, 1, 2'd0, 0, 0, 0, 0, 0, 0, 0); step();
    chk("pre_rst_stall", {31'd0, wb_stall}, 32'd1);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2 reset_n = 1'b0;
    mon_en = 0;
    #1;
    chk("arst_write", {31'd0, control_reg_write}, 32'd0);
    chk("arst_id", {27'd0, control_write_id}, 32'd0);
    chk("arst_value", reg_write_value, 32'd0);
    chk("arst_count", retired_count, 32'd0);
    chk("arst_stall", {31'd0, wb_stall}, 32'd0);
    m_pending = 0; m_count = 0; exp_stall = 0;
    @(negedge clock) reset_n = 1'b1;
    @(posedge clock); #1;
    mon_en = 1;

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      set_in($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 8,
             ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
             $urandom, $urandom_range(0, 9) < 4, 2'($urandom), 1'($urandom), 2'($urandom),
             $urandom_range(0, 9) == 0, $urandom, $urandom_range(0, 9) == 0,
             $urandom, $urandom_range(0, 9) < 6);
      step();
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0); step();
    idle();
    idle();
    chk("rand_count", retired_count, m_count);
    chk("sb_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
